// File: rtl/antialias_granule_scheduler_pkg.sv
// Shared types and granule geometry for the antialias granule scheduler.
// Frame layout is fixed by the mp3 format: two granules of 576 samples.
package antialias_granule_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DS,
      START,
      LOAD,
      DRAIN,
      GR_DONE
   } sched_state_t;

   localparam int SAMPLES_PER_GR = 576;
   localparam int PAIRS_PER_GR   = 288;
   localparam int GR_PER_FRAME   = 2;

   typedef struct packed {
      logic       ws_flag;
      logic [1:0] block_type;
      logic       mixed_flag;
   } gr_side_info_t;

endpackage

// File: rtl/antialias_granule_scheduler.sv
// Granule sequencer in front of antialias: latches side info per frame, gates
// stereo samples into antialias when downstream has room, tracks drain.
module antialias_granule_scheduler
   import antialias_granule_scheduler_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start_in,
   input  logic [1:0] ws_flag_in,
   input  logic [3:0] block_type_in,
   input  logic [1:0] mixed_flag_in,
   input  logic       st_din_v,
   output logic       st_ready,
   input  logic       ds_ready,
   output logic       aa_new_frame_start,
   output logic       aa_din_v,
   output logic       aa_ws_flag,
   output logic [1:0] aa_block_type,
   output logic       aa_mixed_flag,
   input  logic       aa_dout_v,
   output logic       gr_idx,
   output logic       gr_done,
   output logic       frame_done,
   output logic       busy,
   output logic       timeout_err,
   output logic       overrun_err
);

   localparam int CYC_W = $clog2(DRAIN_TIMEOUT) + 1;

   sched_state_t                     state, nxt;
   logic [9:0]                       in_cnt;
   logic [8:0]                       out_cnt;
   logic [CYC_W-1:0]                 cyc_cnt;
   gr_side_info_t [GR_PER_FRAME-1:0] side_q;
   gr_side_info_t                    cur_side;
   logic                             to_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt                = state;
      st_ready           = 1'b0;
      aa_new_frame_start = 1'b0;
      gr_done            = 1'b0;
      frame_done         = 1'b0;
      to_hit             = 1'b0;
      case (state)
         IDLE:    if (frame_start_in) nxt = WAIT_DS;
         WAIT_DS: if (ds_ready) nxt = START;
         START: begin
            aa_new_frame_start = 1'b1;
            nxt                = LOAD;
         end
         LOAD: begin
            st_ready = 1'b1;
            if (st_din_v && in_cnt == 10'(SAMPLES_PER_GR - 1)) nxt = DRAIN;
         end
         DRAIN: begin
            // A completing pair wins over a timeout landing in the same cycle.
            if (aa_dout_v && out_cnt == 9'(PAIRS_PER_GR - 1)) begin
               nxt = GR_DONE;
            end else if (cyc_cnt == CYC_W'(DRAIN_TIMEOUT - 1)) begin
               nxt    = GR_DONE;
               to_hit = 1'b1;
            end
         end
         GR_DONE: begin
            gr_done    = 1'b1;
            frame_done = (gr_idx == 1'(GR_PER_FRAME - 1));
            nxt        = frame_done ? IDLE : WAIT_DS;
         end
         default: nxt = IDLE;
      endcase
   end

   assign aa_din_v = st_ready & st_din_v;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt      <= '0;
         out_cnt     <= '0;
         cyc_cnt     <= '0;
         side_q      <= '0;
         gr_idx      <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         // Frames never overlap; a start pulse outside IDLE is only flagged.
         if (frame_start_in && state != IDLE) overrun_err <= 1'b1;
         if (to_hit) timeout_err <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_start_in) begin
                  for (int g = 0; g < GR_PER_FRAME; g++) begin
                     side_q[g].ws_flag    <= ws_flag_in[g];
                     side_q[g].block_type <= block_type_in[2*g +: 2];
                     side_q[g].mixed_flag <= mixed_flag_in[g];
                  end
                  gr_idx <= 1'b0;
               end
            end
            START: begin
               in_cnt  <= '0;
               out_cnt <= '0;
               cyc_cnt <= '0;
            end
            LOAD: if (aa_din_v) in_cnt <= in_cnt + 10'd1;
            DRAIN: begin
               if (aa_dout_v) out_cnt <= out_cnt + 9'd1;
               cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
            GR_DONE: if (!frame_done) gr_idx <= gr_idx + 1'b1;
            default: ;
         endcase
      end
   end

   assign cur_side      = side_q[gr_idx];
   assign aa_ws_flag    = cur_side.ws_flag;
   assign aa_block_type = cur_side.block_type;
   assign aa_mixed_flag = cur_side.mixed_flag;

endmodule

// File: doc/antialias_granule_scheduler.md
Name: antialias_granule_scheduler

Overview:
Sequences the antialias stage granule by granule within each frame. It latches per-granule side info at frame start and gates stereo-module samples into antialias only when the downstream hybrid/IMDCT stage has room. It pulses antialias new_frame_start before each granule, counts 576 input samples and 288 output pairs, and reports granule and frame completion. It sits between the stereo module and antialias, and also drives the side-info inputs of antialias.

Parameters:
SAMPLES_PER_GR, 576, input samples (channel pairs) per granule.
PAIRS_PER_GR, 288, antialias output pairs per granule.
GR_PER_FRAME, 2, granules per frame.
DRAIN_TIMEOUT, 1024, maximum cycles in DRAIN before timeout_err.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_start_in  in  1  one-cycle pulse; side info below valid this cycle
ws_flag_in  in  2  window_switching_flag, bit g = granule g
block_type_in  in  4  block_type, bits [2g+1:2g] = granule g
mixed_flag_in  in  2  mixed_block_flag, bit g = granule g
st_din_v  in  1  stereo sample pair valid
st_ready  out  1  scheduler accepts stereo samples
ds_ready  in  1  downstream has space for one full granule (288 pairs)
aa_new_frame_start  out  1  reset pulse to antialias
aa_din_v  out  1  gated sample valid to antialias
aa_ws_flag  out  1  current granule window_switching_flag
aa_block_type  out  2  current granule block_type
aa_mixed_flag  out  1  current granule mixed_block_flag
aa_dout_v  in  1  antialias output pair valid
gr_idx  out  1  current granule index
gr_done  out  1  one-cycle pulse, granule drained
frame_done  out  1  one-cycle pulse, last granule drained
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; DRAIN exceeded DRAIN_TIMEOUT
overrun_err  out  1  sticky; frame_start_in seen while busy

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counters 0; latched side info 0; both sticky errors cleared.
- Side info is registered on frame_start_in in IDLE. aa_* side-info outputs are the latched fields for gr_idx and stay stable through LOAD and DRAIN.
- States:
  - IDLE: on frame_start_in, latch side info, set gr_idx=0, go to WAIT_DS.
  - WAIT_DS: when ds_ready=1, go to START.
  - START: aa_new_frame_start=1 for exactly this cycle; in_cnt=0; go to LOAD.
  - LOAD: st_ready=1; aa_din_v = st_din_v (combinational, same cycle); in_cnt increments per accepted sample. When a sample is accepted with in_cnt == SAMPLES_PER_GR-1, go to DRAIN next cycle with st_ready=0; no sample beyond 576 is forwarded.
  - DRAIN: out_cnt counts aa_dout_v; cyc_cnt counts cycles. When aa_dout_v=1 with out_cnt == PAIRS_PER_GR-1, go to GR_DONE. If cyc_cnt reaches DRAIN_TIMEOUT, set timeout_err and go to GR_DONE.
  - GR_DONE: gr_done=1 for one cycle. If gr_idx == GR_PER_FRAME-1, frame_done=1 in the same cycle and go to IDLE. Otherwise increment gr_idx and go to WAIT_DS.
- st_ready is 0 in every state except LOAD. aa_din_v is never 1 outside LOAD.
- frame_start_in outside IDLE is ignored, except that it sets overrun_err.
- Simultaneous frame_start_in and the GR_DONE→IDLE transition: the pulse is ignored and flagged. Frames do not overlap.
- Counter widths: in_cnt 10 bits, out_cnt 9 bits, cyc_cnt clog2(DRAIN_TIMEOUT)+1 bits. No wrap occurs within legal operation.
- Minimum granule latency from START with continuous valids: 1 (START) + 576 (LOAD) + 288 + antialias pipeline (4) (DRAIN) + 1 (GR_DONE).

Decomposition:
- Shared mp3 package holds:
  - state enum sched_state_t {IDLE, WAIT_DS, START, LOAD, DRAIN, GR_DONE};
  - localparams SAMPLES_PER_GR=576, PAIRS_PER_GR=288, GR_PER_FRAME=2;
  - struct gr_side_info_t {ws_flag, block_type[1:0], mixed_flag}.
- No sub-module; the FSM and three counters fit in one module.

Test Plan:
- Reset mid-LOAD at in_cnt=300 → next cycle IDLE, st_ready=0, busy=0, all outputs 0.
- frame_start_in with ws=2'b10, block_type=4'b1000, mixed=2'b00, ds_ready=1, 576 continuous st_din_v, 288 aa_dout_v → aa_new_frame_start pulses once, aa_block_type=0 for gr0, gr_done; then aa_block_type=2 and aa_ws_flag=1 for gr1, frame_done coincident with the second gr_done.
- ds_ready held 0 for 50 cycles after frame_start_in → remains in WAIT_DS, no aa_new_frame_start, st_ready=0; proceeds 1 cycle after ds_ready rises.
- st_din_v toggling every other cycle plus 10 extra valids after the 576th → exactly 576 aa_din_v pulses per granule; extras not forwarded (st_ready=0).
- Only 287 aa_dout_v in DRAIN, DRAIN_TIMEOUT=1024 → timeout_err=1 at cycle 1024, gr_done pulses, gr_idx advances.
- frame_start_in during LOAD → overrun_err=1, side info and gr_idx unchanged, frame completes normally.
